test_ram: RTL and testbench



---
 rtl/test_ram_pkg.sv | 17 +
 rtl/test_ram_bank.sv | 47 ++++
 rtl/test_ram.sv | 94 +++++++++
 tb/tb_test_ram.sv | 135 +++++++++++++
 4 files changed

// File: rtl/test_ram_pkg.sv
// Shared types and constants for the test_ram history store.
// Optional build macro used by the top level: TEST_RAM_BYPASS_EN.
package test_ram_pkg;

  localparam int LANES         = 4;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef logic [DEFAULT_WIDTH-1:0] lane_t;
  typedef lane_t [LANES-1:0]        word_t;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/test_ram_bank.sv
// Circular word store: DEPTH entries of LANES x WIDTH, one write port at wp,
// one read port at wp-1 (the most recently written entry). The read data is
// forced to zero until at least one word has been written since reset.
module test_ram_bank
  import test_ram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic [LANES-1:0][WIDTH-1:0] wdata_i,
  output logic [LANES-1:0][WIDTH-1:0] rdata_o
);

  localparam int PW = ptr_width(DEPTH);

  logic [LANES-1:0][WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]               wp_q, wp_d;
  logic [PW-1:0]               rp;
  logic [1:0]                  cnt_q, cnt_d;

  // Next pointer wraps naturally at DEPTH; valid count saturates at two.
  always_comb begin
    wp_d  = wp_q + PW'(1);
    cnt_d = cnt_q;
    if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
  end

  // Storage, pointer and count update; reset wipes all history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else if (we_i) begin
      mem_q[wp_q] <= wdata_i;
      wp_q        <= wp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rp      = wp_q - PW'(1);
  assign rdata_o = (cnt_q == 2'd0) ? '0 : mem_q[rp];

endmodule

// File: rtl/test_ram.sv
// Four-lane history store for the Viterbi datapath. Newest stored word on
// out1..4, the one before it on out5..8, both registered.
// Build macro TEST_RAM_BYPASS_EN: while st is high, out1..4 show the inputs
// combinationally and out5..8 show the current newest-word register.
module test_ram
  import test_ram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8
);

  logic [LANES-1:0][WIDTH-1:0] in_w;
  logic [LANES-1:0][WIDTH-1:0] rd_w;
  logic [LANES-1:0][WIDTH-1:0] new_q, new_d;
  logic [LANES-1:0][WIDTH-1:0] old_q, old_d;
  logic [LANES-1:0][WIDTH-1:0] new_view;
  logic [LANES-1:0][WIDTH-1:0] old_view;

  assign in_w = {in4, in3, in2, in1};

  test_ram_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (st),
    .wdata_i (in_w),
    .rdata_o (rd_w)
  );

  // On a store the newest word is the input and the previous is the bank's
  // last-written entry (zero when the bank is empty).
  always_comb begin
    new_d = new_q;
    old_d = old_q;
    if (st) begin
      new_d = in_w;
      old_d = rd_w;
    end
  end

  // Output registers; reset overrides a same-edge store.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_q <= '0;
      old_q <= '0;
    end else begin
      new_q <= new_d;
      old_q <= old_d;
    end
  end

`ifdef TEST_RAM_BYPASS_EN
  // Write-through view while a store is being presented.
  always_comb begin
    new_view = new_q;
    old_view = old_q;
    if (st) begin
      new_view = in_w;
      old_view = new_q;
    end
  end
`else
  assign new_view = new_q;
  assign old_view = old_q;
`endif

  assign out1 = new_view[0];
  assign out2 = new_view[1];
  assign out3 = new_view[2];
  assign out4 = new_view[3];
  assign out5 = old_view[0];
  assign out6 = old_view[1];
  assign out7 = old_view[2];
  assign out8 = old_view[3];

endmodule

// File: tb/tb_test_ram.sv
// Bench for test_ram: directed plan items plus random strobes/resets checked
// against a two-deep history queue.
module tb_test_ram;

  logic       clk;
  logic       rst;
  logic       st;
  logic [7:0] in1, in2, in3, in4;
  logic [7:0] out1, out2, out3, out4, out5, out6, out7, out8;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] hist_q [$];

  test_ram #(.WIDTH(8), .DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .st   (st),
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .in4  (in4),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3),
    .out4 (out4),
    .out5 (out5),
    .out6 (out6),
    .out7 (out7),
    .out8 (out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] w4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [63:0] obs_all();
    return {out8, out7, out6, out5, out4, out3, out2, out1};
  endfunction

  // Expected outputs as seen mid-cycle with the current inputs applied.
  function automatic logic [63:0] model_view();
    logic [31:0] nw, pw;
    nw = (hist_q.size() > 0) ? hist_q[0] : 32'h0;
    pw = (hist_q.size() > 1) ? hist_q[1] : 32'h0;
`ifdef TEST_RAM_BYPASS_EN
    if (st) return {nw, in4, in3, in2, in1};
`endif
    return {pw, nw};
  endfunction

  // One clock cycle: apply inputs, check mid-cycle, then advance the model.
  task automatic cyc(input bit r, input bit s, input logic [31:0] w, input bit do_chk, input string tag);
    rst = r;
    st  = s;
    {in4, in3, in2, in1} = w;
    @(negedge clk);
    if (do_chk) chk(tag, obs_all(), model_view());
    @(posedge clk);
    if (r) hist_q.delete();
    else if (s) begin
      hist_q.push_front(w);
      if (hist_q.size() > 2) void'(hist_q.pop_back());
    end
    #1;
  endtask

  // Idle cycle with a constant expectation on the registered outputs.
  task automatic idle_exp(input string tag, input logic [63:0] exp);
    rst = 1'b0;
    st  = 1'b0;
    {in4, in3, in2, in1} = $urandom;
    @(negedge clk);
    chk(tag, obs_all(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    st  = 1'b0;
    {in4, in3, in2, in1} = '0;
    @(posedge clk);
    #1;

    // Reset with a concurrent strobe: no write, all outputs cleared.
    cyc(1'b1, 1'b1, $urandom, 1'b0, "rst0");
    idle_exp("reset_zero", 64'h0);

    // First store, second store three cycles later, third store.
    cyc(1'b0, 1'b1, w4(0, 1, 2, 3), 1'b1, "st1_view");
    idle_exp("first_store", {32'h0, w4(0, 1, 2, 3)});
    cyc(1'b0, 1'b0, $urandom, 1'b1, "gap");
    cyc(1'b0, 1'b1, w4(1, 2, 3, 4), 1'b1, "st2_view");
    idle_exp("second_store", {w4(0, 1, 2, 3), w4(1, 2, 3, 4)});
    cyc(1'b0, 1'b1, w4(3, 4, 5, 6), 1'b1, "st3_view");
    idle_exp("third_store", {w4(1, 2, 3, 4), w4(3, 4, 5, 6)});

    // Hold: inputs wander with st low.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, $urandom, 1'b1, "hold");
    idle_exp("hold_const", {w4(1, 2, 3, 4), w4(3, 4, 5, 6)});

    // Wrap through DEPTH with back-to-back strobes.
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, w4(k, k + 1, k + 2, k + 3), 1'b1, "wrap_view");
    idle_exp("wrap_final", {w4(4, 5, 6, 7), w4(5, 6, 7, 8)});

    // Mid-stream reset discards history.
    cyc(1'b0, 1'b1, $urandom, 1'b1, "mid_st_a");
    cyc(1'b0, 1'b1, $urandom, 1'b1, "mid_st_b");
    cyc(1'b1, 1'b0, $urandom, 1'b1, "mid_rst");
    cyc(1'b0, 1'b1, w4(9, 10, 11, 12), 1'b1, "post_rst_view");
    idle_exp("post_rst_store", {32'h0, w4(9, 10, 11, 12)});

    // Random strobes with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1, $urandom, 1'b1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
